// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: instruction memory port, hazard/redirect inputs, IF/ID outputs
//
// Signals:
//   imem_addr      fetch -> memory, word address (equals pc)
//   imem_data      memory -> fetch, read data for imem_addr in the same cycle
//   stall          hazard logic -> fetch, hold the whole stage
//   branch_taken   execute -> fetch, redirect request
//   branch_target  execute -> fetch, new pc on redirect
//   instr_out      fetch -> decode, opcode word
//   imm_out        fetch -> decode, immediate word (0 for one-word instructions)
//   pc_out         fetch -> decode, address of the opcode word
//   valid_out      fetch -> decode, IF/ID holds a real instruction
// Modports: master = fetch stage side, slave = surrounding pipeline/memory side.
interface fetch_stage_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [15:0]       instr_out;
    logic [15:0]       imm_out;
    logic [ADDR_W-1:0] pc_out;
    logic              valid_out;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  branch_taken,
        input  branch_target,
        output instr_out,
        output imm_out,
        output pc_out,
        output valid_out
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output branch_taken,
        output branch_target,
        input  instr_out,
        input  imm_out,
        input  pc_out,
        input  valid_out
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, two-word assembly FSM and IF/ID register
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fetch_stage_if.master: imem_addr/imem_data read port, stall, branch_taken,
//          branch_target, and registered IF/ID outputs instr_out, imm_out, pc_out, valid_out
module fetch_stage #(
    parameter int          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    typedef enum logic {S_OP, S_IMM} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [15:0]       op_hold, op_hold_n;
    logic [ADDR_W-1:0] op_pc, op_pc_n;
    logic [15:0]       instr_q, instr_n;
    logic [15:0]       imm_q, imm_n;
    logic [ADDR_W-1:0] pc_out_q, pc_out_n;
    logic              valid_q, valid_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_OP;
            pc       <= RESET_PC;
            op_hold  <= '0;
            op_pc    <= '0;
            instr_q  <= NOP_WORD;
            imm_q    <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            op_hold  <= op_hold_n;
            op_pc    <= op_pc_n;
            instr_q  <= instr_n;
            imm_q    <= imm_n;
            pc_out_q <= pc_out_n;
            valid_q  <= valid_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        op_hold_n = op_hold;
        op_pc_n   = op_pc;
        instr_n   = instr_q;
        imm_n     = imm_q;
        pc_out_n  = pc_out_q;
        valid_n   = valid_q;

        if (bus.branch_taken) begin
            // Redirect wins over stall and drops any half-fetched two-word instruction.
            pc_n    = bus.branch_target;
            state_n = S_OP;
            instr_n = NOP_WORD;
            imm_n   = '0;
            valid_n = 1'b0;
        end else if (!bus.stall) begin
            pc_n = pc + 1'b1;
            case (state)
                S_OP: begin
                    if (bus.imem_data[15]) begin
                        // Opcode of a two-word instruction: park it and emit a bubble.
                        op_hold_n = bus.imem_data;
                        op_pc_n   = pc;
                        state_n   = S_IMM;
                        instr_n   = NOP_WORD;
                        imm_n     = '0;
                        valid_n   = 1'b0;
                    end else begin
                        instr_n  = bus.imem_data;
                        imm_n    = '0;
                        pc_out_n = pc;
                        valid_n  = 1'b1;
                    end
                end
                S_IMM: begin
                    instr_n  = op_hold;
                    imm_n    = bus.imem_data;
                    pc_out_n = op_pc;
                    valid_n  = 1'b1;
                    state_n  = S_OP;
                end
                default: state_n = S_OP;
            endcase
        end
    end

    assign bus.imem_addr = pc;
    assign bus.instr_out = instr_q;
    assign bus.imm_out   = imm_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.valid_out = valid_q;
endmodule
